// File: rtl/spi_flash_arbiter.sv
// Shares the quad-SPI flash reader between the fetch and memory-unit ports.
// Round-robin grant, recvDone edge detection, and an optional single-word read buffer.
module spi_flash_arbiter #(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [23:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_data,
    input  logic        mu_req,
    input  logic [23:0] mu_addr,
    output logic        mu_ack,
    output logic [31:0] mu_data,
    input  logic        flush,
    output logic        spi_start,
    output logic [23:0] spi_address,
    input  logic [31:0] spi_instr,
    input  logic        spi_initDone,
    input  logic        spi_recvDone
);

    typedef enum logic [2:0] {INIT, IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_MU = 1'b1;

    state_t      state;
    state_t      state_next;

    logic        last_grant;
    logic        cur_port;
    logic [23:0] cur_addr;
    logic        rd_q;

    logic        buf_valid;
    logic [23:0] buf_addr;
    logic [31:0] buf_data;

    logic        grant_mu;
    logic [23:0] gnt_addr;
    logic        hit;
    logic        rise;
    logic        issue;
    logic        resp_en;
    logic        resp_port;
    logic [31:0] resp_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // Loss of reader initialisation overrides every other transition.
    always_comb begin
        state_next = state;
        grant_mu   = mu_req && (!if_req || (last_grant == PORT_IF));
        gnt_addr   = grant_mu ? mu_addr : if_addr;
        hit        = CACHE_EN && buf_valid && !flush && (gnt_addr == buf_addr);
        rise       = spi_recvDone && !rd_q;
        issue      = 1'b0;
        resp_en    = 1'b0;
        resp_port  = cur_port;
        resp_data  = spi_instr;

        case (state)
            INIT: begin
                if (spi_initDone) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (if_req || mu_req) begin
                    if (hit) begin
                        state_next = RESP;
                        resp_en    = 1'b1;
                        resp_port  = grant_mu;
                        resp_data  = buf_data;
                    end else begin
                        state_next = ISSUE;
                        issue      = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (!spi_recvDone) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (rise) begin
                    state_next = RESP;
                    resp_en    = 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = INIT;
            end
        endcase

        if (!spi_initDone) begin
            state_next = INIT;
            issue      = 1'b0;
            resp_en    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q        <= 1'b0;
            if_ack      <= 1'b0;
            mu_ack      <= 1'b0;
            if_data     <= 32'h0;
            mu_data     <= 32'h0;
            spi_start   <= 1'b0;
            spi_address <= 24'h0;
            cur_addr    <= 24'h0;
            cur_port    <= PORT_IF;
            last_grant  <= PORT_IF;
            buf_valid   <= 1'b0;
            buf_addr    <= 24'h0;
            buf_data    <= 32'h0;
        end else begin
            rd_q      <= spi_recvDone;
            if_ack    <= resp_en && (resp_port == PORT_IF);
            mu_ack    <= resp_en && (resp_port == PORT_MU);
            spi_start <= (state_next == ISSUE) || (state_next == WAIT);

            if (resp_en && (resp_port == PORT_IF)) begin
                if_data <= resp_data;
            end
            if (resp_en && (resp_port == PORT_MU)) begin
                mu_data <= resp_data;
            end

            if ((state == IDLE) && (if_req || mu_req)) begin
                cur_addr <= gnt_addr;
                cur_port <= grant_mu;
            end

            if (issue) begin
                spi_address <= gnt_addr;
            end

            if (state == RESP) begin
                last_grant <= cur_port;
            end

            // A refill from an in-flight read wins over a flush in the same cycle.
            if ((state_next == INIT) || flush) begin
                buf_valid <= 1'b0;
            end
            if ((state == WAIT) && resp_en) begin
                buf_valid <= 1'b1;
                buf_addr  <= cur_addr;
                buf_data  <= spi_instr;
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter; the reader handshake is driven by hand.
// A second instance built without the read buffer is held in reset until the final section.
module tb_spi_flash_arbiter;

    logic        clk;
    logic        reset;
    logic        nc_reset;
    logic        if_req;
    logic [23:0] if_addr;
    logic        mu_req;
    logic [23:0] mu_addr;
    logic        flush;
    logic [31:0] spi_instr;
    logic        spi_initDone;
    logic        spi_recvDone;

    logic        if_ack;
    logic [31:0] if_data;
    logic        mu_ack;
    logic [31:0] mu_data;
    logic        spi_start;
    logic [23:0] spi_address;

    logic        nc_if_ack;
    logic [31:0] nc_if_data;
    logic        nc_mu_ack;
    logic [31:0] nc_mu_data;
    logic        nc_spi_start;
    logic [23:0] nc_spi_address;

    int checks = 0;
    int errors = 0;

    spi_flash_arbiter #(.CACHE_EN(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_ack       (if_ack),
        .if_data      (if_data),
        .mu_req       (mu_req),
        .mu_addr      (mu_addr),
        .mu_ack       (mu_ack),
        .mu_data      (mu_data),
        .flush        (flush),
        .spi_start    (spi_start),
        .spi_address  (spi_address),
        .spi_instr    (spi_instr),
        .spi_initDone (spi_initDone),
        .spi_recvDone (spi_recvDone)
    );

    spi_flash_arbiter #(.CACHE_EN(1'b0)) dut_nc (
        .clk          (clk),
        .reset        (nc_reset),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_ack       (nc_if_ack),
        .if_data      (nc_if_data),
        .mu_req       (mu_req),
        .mu_addr      (mu_addr),
        .mu_ack       (nc_mu_ack),
        .mu_data      (nc_mu_data),
        .flush        (flush),
        .spi_start    (nc_spi_start),
        .spi_address  (nc_spi_address),
        .spi_instr    (spi_instr),
        .spi_initDone (spi_initDone),
        .spi_recvDone (spi_recvDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reader raises recvDone with the word for one cycle; the ack is visible right after.
    task automatic reader_complete(input logic [31:0] word);
        spi_instr    = word;
        spi_recvDone = 1'b1;
        tick();
        spi_recvDone = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        nc_reset     = 1'b0;
        if_req       = 1'b0;
        if_addr      = 24'h0;
        mu_req       = 1'b0;
        mu_addr      = 24'h0;
        flush        = 1'b0;
        spi_instr    = 32'h0;
        spi_initDone = 1'b0;
        spi_recvDone = 1'b0;
        tick();
        tick();

        check_output("rst_if_ack", {31'h0, if_ack}, 32'h0);
        check_output("rst_mu_ack", {31'h0, mu_ack}, 32'h0);
        check_output("rst_if_data", if_data, 32'h0);
        check_output("rst_mu_data", mu_data, 32'h0);
        check_output("rst_spi_start", {31'h0, spi_start}, 32'h0);
        check_output("rst_spi_address", {8'h0, spi_address}, 32'h0);

        // Request while the reader is still initialising.
        reset   = 1'b1;
        if_req  = 1'b1;
        if_addr = 24'h000010;
        for (int i = 0; i < 10; i++) tick();
        check_output("init_no_start", {31'h0, spi_start}, 32'h0);

        spi_initDone = 1'b1;
        tick();
        tick();
        check_output("miss_start", {31'h0, spi_start}, 32'h1);
        check_output("miss_address", {8'h0, spi_address}, 32'h000010);
        tick();
        reader_complete(32'hDEADBEEF);
        check_output("miss_if_ack", {31'h0, if_ack}, 32'h1);
        check_output("miss_if_data", if_data, 32'hDEADBEEF);
        check_output("miss_start_drop", {31'h0, spi_start}, 32'h0);
        check_output("miss_mu_ack", {31'h0, mu_ack}, 32'h0);
        if_req = 1'b0;
        tick();
        check_output("miss_ack_pulse", {31'h0, if_ack}, 32'h0);

        // Same word again is served from the buffer.
        if_req = 1'b1;
        tick();
        check_output("hit_if_ack", {31'h0, if_ack}, 32'h1);
        check_output("hit_no_start", {31'h0, spi_start}, 32'h0);
        check_output("hit_if_data", if_data, 32'hDEADBEEF);
        if_req = 1'b0;
        tick();
        check_output("hit_ack_pulse", {31'h0, if_ack}, 32'h0);
        check_output("hit_mu_data", mu_data, 32'h0);

        // Flush coincident with the compare forces a flash read.
        if_req = 1'b1;
        flush  = 1'b1;
        tick();
        flush = 1'b0;
        check_output("flush_start", {31'h0, spi_start}, 32'h1);
        check_output("flush_no_ack", {31'h0, if_ack}, 32'h0);
        tick();
        reader_complete(32'h12345678);
        check_output("flush_if_ack", {31'h0, if_ack}, 32'h1);
        check_output("flush_if_data", if_data, 32'h12345678);
        if_req = 1'b0;
        tick();

        // Sustained contention alternates mu, if, mu, if.
        if_req  = 1'b1;
        if_addr = 24'h000020;
        mu_req  = 1'b1;
        mu_addr = 24'h000030;
        for (int i = 0; i < 4; i++) begin
            logic        exp_mu;
            logic [31:0] word;
            exp_mu = (i % 2) == 0;
            word   = 32'hC0DE0000 | i;
            tick();
            check_output("rr_address", {8'h0, spi_address}, exp_mu ? 32'h000030 : 32'h000020);
            tick();
            reader_complete(word);
            check_output("rr_mu_ack", {31'h0, mu_ack}, {31'h0, exp_mu});
            check_output("rr_if_ack", {31'h0, if_ack}, {31'h0, !exp_mu});
            check_output("rr_data", exp_mu ? mu_data : if_data, word);
            tick();
        end
        if_req = 1'b0;
        mu_req = 1'b0;
        tick();

        // recvDone still high from a previous read when start rises.
        if_req       = 1'b1;
        if_addr      = 24'h000040;
        spi_recvDone = 1'b1;
        tick();
        check_output("stale_start", {31'h0, spi_start}, 32'h1);
        tick();
        check_output("stale_no_ack1", {31'h0, if_ack}, 32'h0);
        spi_recvDone = 1'b0;
        tick();
        check_output("stale_no_ack2", {31'h0, if_ack}, 32'h0);
        check_output("stale_start_held", {31'h0, spi_start}, 32'h1);
        reader_complete(32'h40404040);
        check_output("stale_if_ack", {31'h0, if_ack}, 32'h1);
        check_output("stale_if_data", if_data, 32'h40404040);
        if_req = 1'b0;
        tick();

        // Reader loses initialisation mid-read; the request is re-served after re-init.
        if_req  = 1'b1;
        if_addr = 24'h000050;
        tick();
        tick();
        spi_initDone = 1'b0;
        tick();
        check_output("drop_start", {31'h0, spi_start}, 32'h0);
        check_output("drop_no_ack", {31'h0, if_ack}, 32'h0);
        spi_initDone = 1'b1;
        tick();
        check_output("reinit_no_ack", {31'h0, if_ack}, 32'h0);
        tick();
        check_output("reinit_start", {31'h0, spi_start}, 32'h1);
        check_output("reinit_address", {8'h0, spi_address}, 32'h000050);
        tick();
        reader_complete(32'h50505050);
        check_output("reinit_if_ack", {31'h0, if_ack}, 32'h1);
        check_output("reinit_if_data", if_data, 32'h50505050);
        if_req = 1'b0;
        tick();
        check_output("reinit_ack_once", {31'h0, if_ack}, 32'h0);

        // A valid buffered word is dropped by passing through INIT.
        spi_initDone = 1'b0;
        tick();
        spi_initDone = 1'b1;
        tick();
        if_req = 1'b1;
        tick();
        check_output("inval_start", {31'h0, spi_start}, 32'h1);
        check_output("inval_no_hit", {31'h0, if_ack}, 32'h0);
        tick();
        reader_complete(32'h50505051);
        check_output("inval_if_data", if_data, 32'h50505051);
        if_req = 1'b0;
        tick();

        // Asynchronous reset while waiting on the reader.
        mu_req  = 1'b1;
        mu_addr = 24'h000070;
        tick();
        tick();
        check_output("rst_wait_start", {31'h0, spi_start}, 32'h1);
        reset = 1'b0;
        #1;
        check_output("arst_spi_start", {31'h0, spi_start}, 32'h0);
        check_output("arst_spi_address", {8'h0, spi_address}, 32'h0);
        check_output("arst_if_data", if_data, 32'h0);
        check_output("arst_mu_data", mu_data, 32'h0);
        tick();
        reset  = 1'b1;
        mu_req = 1'b0;
        spi_recvDone = 1'b1;
        tick();
        spi_recvDone = 1'b0;
        tick();
        check_output("arst_stale_mu_ack", {31'h0, mu_ack}, 32'h0);
        check_output("arst_stale_if_ack", {31'h0, if_ack}, 32'h0);
        check_output("arst_stale_start", {31'h0, spi_start}, 32'h0);
        tick();
        check_output("arst_stale_mu_ack2", {31'h0, mu_ack}, 32'h0);

        // Build without the buffer never hits on a repeated address.
        nc_reset = 1'b1;
        tick();
        if_req  = 1'b1;
        if_addr = 24'h000080;
        tick();
        check_output("nc_first_start", {31'h0, nc_spi_start}, 32'h1);
        check_output("c_first_start", {31'h0, spi_start}, 32'h1);
        tick();
        reader_complete(32'h80808080);
        check_output("nc_first_ack", {31'h0, nc_if_ack}, 32'h1);
        check_output("nc_first_data", nc_if_data, 32'h80808080);
        if_req = 1'b0;
        tick();
        if_req = 1'b1;
        tick();
        check_output("c_repeat_hit", {31'h0, if_ack}, 32'h1);
        check_output("c_repeat_no_start", {31'h0, spi_start}, 32'h0);
        check_output("nc_repeat_start", {31'h0, nc_spi_start}, 32'h1);
        check_output("nc_repeat_no_ack", {31'h0, nc_if_ack}, 32'h0);
        if_req = 1'b0;
        tick();
        tick();
        reader_complete(32'h80808081);
        check_output("nc_dropped_req_ack", {31'h0, nc_if_ack}, 32'h1);
        check_output("nc_repeat_data", nc_if_data, 32'h80808081);
        check_output("c_idle_no_ack", {31'h0, if_ack}, 32'h0);
        check_output("c_data_stable", if_data, 32'h80808080);
        tick();
        check_output("nc_ack_pulse", {31'h0, nc_if_ack}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_flash_arbiter.md
# spi_flash_arbiter

Sequences and shares the quad-SPI flash reader between two requesters: the instruction fetch port (`if_`) and the memory-unit data port (`mu_`). It waits for reader initialisation, arbitrates round-robin, and drives the reader's `start`/`address` handshake. It detects completion on the rising edge of `recvDone` and returns the 32-bit word to the granted requester. A single-entry last-word buffer serves repeated reads of the same word address without a flash transaction.

## Interface
- `CACHE_EN`, default 1: 1 enables the single-entry last-word buffer; 0 sends every request to flash.
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request, level; held until `if_ack`.
- `if_addr`  in  24  fetch word address.
- `if_ack`  out  1  one-cycle completion pulse.
- `if_data`  out  32  fetch result; stable from `if_ack` until the next `if_ack`.
- `mu_req`, `mu_addr`, `mu_ack`, `mu_data`: same as the `if_` set, for the data port.
- `flush`  in  1  one-cycle pulse; invalidates the last-word buffer.
- `spi_start`  out  1  reader start, level.
- `spi_address`  out  24  reader word address.
- `spi_instr`  in  32  reader result.
- `spi_initDone`  in  1  reader initialised.
- `spi_recvDone`  in  1  reader completion flag.

## Operation
- States: INIT, IDLE, ISSUE, WAIT, RESP.
- INIT: stays in INIT while `spi_initDone`=0, then goes to IDLE. The buffer is invalid in INIT.
- IDLE, grant selection:
  - Only one requester active: grant it.
  - Both active: grant the one not granted last.
  - `last_grant` resets to fetch, so the first contended grant goes to mu.
  - The granted address is latched into `cur_addr` and `cur_port` is recorded.
- IDLE, hit path: on a hit (`CACHE_EN`=1, buffer valid, `cur_addr`==`buf_addr`, no `flush` this cycle), go to RESP with `buf_data`.
- IDLE, miss path: on a miss, drive `spi_address`=`cur_addr`, assert `spi_start`, and go to ISSUE.
- ISSUE: `spi_start` is held high. Move to WAIT once `spi_recvDone` is sampled low.
- WAIT: `spi_start` stays high until the first rising edge of `spi_recvDone`.
  - Rising edge means `spi_recvDone`=1 and registered `rd_q`=0.
  - On that edge: drop `spi_start`, capture `spi_instr` into `buf_data`/`buf_addr`, set `buf_valid`, and go to RESP.
- RESP: pulse the ack of `cur_port` for one cycle and load its data register. Update `last_grant`, then return to IDLE.
- A requester that still has `req` high in the cycle after its ack is treated as issuing a new request.
- `spi_address` holds its value outside a transaction.
- Arithmetic: none. Address compare is 24-bit equality.

## Timing
- Reset values:
  - State INIT; `buf_valid`=0; `last_grant`=fetch; `rd_q`=0.
  - All outputs 0: `if_ack`, `mu_ack`, `if_data`, `mu_data`, `spi_start`, `spi_address`.
- Hit latency: `req` sampled in IDLE at edge N → ack high in cycle N+1 → IDLE at N+2. A back-to-back request is accepted at N+2.
- Miss latency: `spi_start` high from N+1. Ack is asserted one cycle after the cycle in which the rising edge of `recvDone` is sampled.
- `flush` coincident with a hit-compare: `flush` wins and the request is a miss.
- `flush` during WAIT: the buffer is cleared, but the in-flight result still refills it.
- `spi_initDone` falling in any state: go to INIT next cycle.
  - Drop `spi_start` and invalidate the buffer; no ack is issued.
  - The requester keeps `req` high and is re-served after re-init.
- `reset` asserted mid-transaction: everything returns immediately (asynchronously) to reset values. A stale `recvDone` pulse after reset is ignored until IDLE→ISSUE→WAIT has been re-entered.
- `req` dropped by a requester while granted: the transaction still completes and the buffer is updated. The ack is still pulsed and must be ignored by the requester.

## Test plan
- Reset, `spi_initDone`=0 for 10 cycles, `if_req`=1, `if_addr`=0x000010 → no `spi_start`. After `initDone`=1: `spi_start` rises, `spi_address`=0x000010; reader model returns 0xDEADBEEF → `if_ack` one cycle, `if_data`=0xDEADBEEF.
- Repeat `if_req` at 0x000010 → `if_ack` exactly 1 cycle after the request, `spi_start` stays 0, `if_data`=0xDEADBEEF. Same request after a `flush` pulse → a flash transaction occurs.
- `if_req` and `mu_req` high together, addresses 0x000020 and 0x000030:
  - mu is served first, then fetch; two transactions.
  - Sustained contention alternates grants mu, if, mu, if.
- `spi_recvDone` already high when `spi_start` rises (reader model holds it one extra cycle) → no premature ack; ack only follows the next rising edge.
- `spi_initDone` drops during WAIT → `spi_start`=0 next cycle, no ack, buffer invalid. After re-init the same address is re-fetched and acked once.
- `reset` pulsed low during WAIT → all outputs 0 immediately. A later `recvDone` pulse produces no ack; `CACHE_EN`=0 build never hits on repeated addresses.
